// File: rtl/centroid_crosshair_if.sv
// centroid_crosshair_if
//   Pixel stream into the centroid/crosshair block and its results out.
//   slave  : the centroid_crosshair block (consumes pixels, drives results)
//   master : the upstream source / consumer side (drives pixels, reads results)
//   Pixel side : hcount_in, vcount_in, data_valid_in, mask_in, frame_done_in
//   Result side: x_out, y_out, centroid_valid_out, lost_out, busy_out, crosshair_out
interface centroid_crosshair_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic        mask_in;
  logic        frame_done_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        centroid_valid_out;
  logic        lost_out;
  logic        busy_out;
  logic        crosshair_out;

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, mask_in, frame_done_in,
    output x_out, y_out, centroid_valid_out, lost_out, busy_out, crosshair_out
  );

  modport master (
    output hcount_in, vcount_in, data_valid_in, mask_in, frame_done_in,
    input  x_out, y_out, centroid_valid_out, lost_out, busy_out, crosshair_out
  );
endinterface

// File: rtl/centroid_crosshair.sv
// centroid_crosshair
//   Accumulates the threshold mask of each camera frame, divides the
//   coordinate sums by the masked-pixel count (two parallel 32-step restoring
//   dividers) and publishes the centroid; draws a crosshair overlay bit
//   through the currently held centroid.
// Ports:
//   clk_in   : pixel clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   pix      : centroid_crosshair_if.slave (pixel stream in, results out)
// Parameters: H_ACTIVE, V_ACTIVE (frame size), MIN_PIXELS (acceptance count).
// Build option: define CROSSHAIR_THICK_EN for 3-pixel-wide crosshair lines.
module centroid_crosshair #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  centroid_crosshair_if.slave   pix
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] DIVIDE  = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  logic [1:0]  state;
  logic [30:0] sum_x;
  logic [29:0] sum_y;
  logic [19:0] cnt;

  // Dividend registers shift out dividend bits at the top and collect
  // quotient bits at the bottom; after 32 steps they hold the quotient.
  logic [31:0] qx, qy;
  logic [19:0] rx, ry;
  logic [19:0] div_d;
  logic [4:0]  step_cnt;
  logic        lost_flag;

  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        lost_q;
  logic        xh_q;

  logic        hit;
  logic [30:0] snap_x;
  logic [29:0] snap_y;
  logic [19:0] snap_cnt;
  logic [20:0] rx_sh, ry_sh;
  logic        rx_ge, ry_ge;
  logic        near_x, near_y;

  // Snapshot includes a masked pixel arriving together with frame_done.
  always_comb begin
    hit      = pix.data_valid_in && pix.mask_in;
    snap_x   = sum_x + (hit ? {20'd0, pix.hcount_in} : '0);
    snap_y   = sum_y + (hit ? {20'd0, pix.vcount_in} : '0);
    snap_cnt = cnt + {19'd0, hit};
    rx_sh    = {rx, qx[31]};
    ry_sh    = {ry, qy[31]};
    rx_ge    = rx_sh >= {1'b0, div_d};
    ry_ge    = ry_sh >= {1'b0, div_d};
  end

`ifdef CROSSHAIR_THICK_EN
  // Widened by one bit so +1 at the top of the range cannot wrap.
  always_comb begin
    near_x = ({1'b0, pix.hcount_in} + 12'd1 >= {1'b0, x_q}) &&
             ({1'b0, pix.hcount_in} <= {1'b0, x_q} + 12'd1);
    near_y = ({1'b0, pix.vcount_in} + 11'd1 >= {1'b0, y_q}) &&
             ({1'b0, pix.vcount_in} <= {1'b0, y_q} + 11'd1);
  end
`else
  always_comb begin
    near_x = pix.hcount_in == x_q;
    near_y = pix.vcount_in == y_q;
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ACCUM;
      sum_x     <= '0;
      sum_y     <= '0;
      cnt       <= '0;
      qx        <= '0;
      qy        <= '0;
      rx        <= '0;
      ry        <= '0;
      div_d     <= '0;
      step_cnt  <= '0;
      lost_flag <= 1'b0;
      x_q       <= 11'(H_ACTIVE / 2);
      y_q       <= 10'(V_ACTIVE / 2);
      lost_q    <= 1'b0;
      xh_q      <= 1'b0;
    end else begin
      // Accumulators clear on every frame_done, published or not.
      if (pix.frame_done_in) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else if (hit) begin
        sum_x <= snap_x;
        sum_y <= snap_y;
        cnt   <= snap_cnt;
      end

      case (state)
        ACCUM: begin
          if (pix.frame_done_in) begin
            qx       <= {1'b0, snap_x};
            qy       <= {2'b0, snap_y};
            div_d    <= snap_cnt;
            rx       <= '0;
            ry       <= '0;
            step_cnt <= '0;
            if (snap_cnt >= 20'(MIN_PIXELS)) begin
              lost_flag <= 1'b0;
              state     <= DIVIDE;
            end else begin
              lost_flag <= 1'b1;
              state     <= PUBLISH;
            end
          end
        end
        DIVIDE: begin
          rx       <= rx_ge ? 20'(rx_sh - {1'b0, div_d}) : rx_sh[19:0];
          ry       <= ry_ge ? 20'(ry_sh - {1'b0, div_d}) : ry_sh[19:0];
          qx       <= {qx[30:0], rx_ge};
          qy       <= {qy[30:0], ry_ge};
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == '1) state <= PUBLISH;
        end
        PUBLISH: begin
          if (!lost_flag) begin
            x_q <= qx[10:0];
            y_q <= qy[9:0];
          end
          lost_q <= lost_flag;
          state  <= ACCUM;
        end
        default: state <= ACCUM;
      endcase

      xh_q <= pix.data_valid_in && (near_x || near_y);
    end
  end

  assign pix.x_out              = x_q;
  assign pix.y_out              = y_q;
  assign pix.lost_out           = lost_q;
  assign pix.crosshair_out      = xh_q;
  assign pix.busy_out           = state == DIVIDE;
  assign pix.centroid_valid_out = state == PUBLISH;

endmodule

// File: tb/tb_centroid_crosshair.sv
// tb_centroid_crosshair
//   Randomized and directed frames against a plain-arithmetic reference:
//   centroid = floor(sum/count) over masked pixels, publish timing, lost
//   frames, dropped frames, reset mid-divide and crosshair overlay.
module tb_centroid_crosshair;
  localparam int MINP = 2;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  centroid_crosshair_if pix();

  centroid_crosshair #(.H_ACTIVE(1280), .V_ACTIVE(720), .MIN_PIXELS(MINP)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .pix      (pix)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  longint sx = 0, sy = 0, sc = 0;
  longint last_sx, last_sy, last_cnt;
  int exp_x = 640, exp_y = 360;
  bit exp_lost = 1'b0;
  int cyc = 0, busy_n = 0, vld_n = 0, vld_cyc = -1;

  task automatic chk(input string tag, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic bit xh_model(input int h, input int v);
`ifdef CROSSHAIR_THICK_EN
    return (iabs(h - exp_x) <= 1) || (iabs(v - exp_y) <= 1);
`else
    return (h == exp_x) || (v == exp_y);
`endif
  endfunction

  // One clock: drive inputs, sample #1 after the edge, update the model.
  task automatic step(input bit v, input bit m, input int h, input int vv, input bit fd);
    pix.data_valid_in = v;
    pix.mask_in       = m;
    pix.hcount_in     = 11'(h);
    pix.vcount_in     = 10'(vv);
    pix.frame_done_in = fd;
    @(posedge clk_in);
    #1;
    cyc++;
    if (v) chk("crosshair", pix.crosshair_out, xh_model(h, vv));
    if (pix.busy_out) busy_n++;
    if (pix.centroid_valid_out) begin
      vld_n++;
      vld_cyc = cyc;
    end
    if (fd) begin
      last_sx  = sx + ((v && m) ? h : 0);
      last_sy  = sy + ((v && m) ? vv : 0);
      last_cnt = sc + ((v && m) ? 1 : 0);
      sx = 0; sy = 0; sc = 0;
    end else if (v && m) begin
      sx += h; sy += vv; sc++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_outputs();
    chk("x_out", pix.x_out, exp_x);
    chk("y_out", pix.y_out, exp_y);
    chk("lost_out", pix.lost_out, exp_lost);
  endtask

  // frame_done (optionally carrying one last pixel), then verify publish.
  task automatic frame_end(input bit v, input bit m, input int h, input int vv);
    int c0;
    bit acc;
    busy_n = 0; vld_n = 0; vld_cyc = -1;
    step(v, m, h, vv, 1'b1);
    c0  = cyc;
    acc = (last_cnt >= MINP);
    while (vld_n == 0 && cyc - c0 < 60) idle();
    chk("publish_latency", vld_cyc - c0, acc ? 32 : 0);
    chk("busy_cycles", busy_n, acc ? 32 : 0);
    idle();
    chk("valid_pulses", vld_n, 1);
    if (acc) begin
      exp_x = int'(last_sx / last_cnt);
      exp_y = int'(last_sy / last_cnt);
    end
    exp_lost = !acc;
    check_outputs();
  endtask

  task automatic rand_pixel(input int pct);
    int h, v;
    h = ($urandom % 4 == 0) ? exp_x + int'($urandom % 3) - 1 : int'($urandom % 1280);
    v = ($urandom % 4 == 0) ? exp_y + int'($urandom % 3) - 1 : int'($urandom % 720);
    if (h < 0) h = 0;
    if (h > 1279) h = 1279;
    if (v < 0) v = 0;
    if (v > 719) v = 719;
    step($urandom % 8 != 0, int'($urandom % 100) < pct, h, v, 1'b0);
  endtask

  initial begin
    int c0, save_x, save_y;
    pix.data_valid_in = 1'b0;
    pix.mask_in       = 1'b0;
    pix.hcount_in     = '0;
    pix.vcount_in     = '0;
    pix.frame_done_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_outputs();
    chk("rst_valid", pix.centroid_valid_out, 0);
    chk("rst_busy", pix.busy_out, 0);
    chk("rst_crosshair", pix.crosshair_out, 0);
    rst_n_in = 1'b1;

    // crosshair through reset centroid
    step(1'b1, 1'b0, 640, 5, 1'b0);
    step(1'b1, 1'b0, 639, 5, 1'b0);
    step(1'b1, 1'b0, 100, 361, 1'b0);
    step(1'b1, 1'b0, 100, 100, 1'b0);

    // two-pixel frame -> (200,100)
    step(1'b1, 1'b1, 100, 50, 1'b0);
    idle();
    step(1'b1, 1'b1, 300, 150, 1'b0);
    frame_end(1'b0, 1'b0, 0, 0);
    chk("dir_x200", pix.x_out, 200);

    // lost frame: one pixel below MIN_PIXELS
    step(1'b1, 1'b1, 900, 600, 1'b0);
    frame_end(1'b0, 1'b0, 0, 0);
    chk("lost_hold_x", pix.x_out, 200);

    // floor: (10,10),(11,10),(11,11), last one with frame_done
    step(1'b1, 1'b1, 10, 10, 1'b0);
    step(1'b1, 1'b1, 11, 10, 1'b0);
    frame_end(1'b1, 1'b1, 11, 11);
    chk("floor_y10", pix.y_out, 10);

    // second frame_done during DIVIDE is dropped
    step(1'b1, 1'b1, 400, 200, 1'b0);
    step(1'b1, 1'b1, 500, 300, 1'b0);
    busy_n = 0; vld_n = 0; vld_cyc = -1;
    step(1'b0, 1'b0, 0, 0, 1'b1);
    c0 = cyc;
    save_x = int'(last_sx / last_cnt);
    save_y = int'(last_sy / last_cnt);
    for (int k = 1; k <= 9; k++) step(1'b1, 1'b1, 20 + k, 30 + k, 1'b0);
    step(1'b1, 1'b1, 1000, 700, 1'b1);
    for (int k = 11; k <= 20; k++) step(1'b1, 1'b1, 50 + k, 60 + k, 1'b0);
    while (cyc - c0 < 40) idle();
    chk("drop_pulses", vld_n, 1);
    chk("drop_latency", vld_cyc - c0, 32);
    exp_x = save_x; exp_y = save_y; exp_lost = 1'b0;
    check_outputs();
    frame_end(1'b0, 1'b0, 0, 0);

    // reset mid-divide
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 700 + k, 400 + k, 1'b0);
    vld_n = 0;
    step(1'b0, 1'b0, 0, 0, 1'b1);
    repeat (14) idle();
    rst_n_in = 1'b0;
    #1;
    sx = 0; sy = 0; sc = 0;
    exp_x = 640; exp_y = 360; exp_lost = 1'b0;
    check_outputs();
    chk("rst_mid_busy", pix.busy_out, 0);
    chk("rst_mid_valid", pix.centroid_valid_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (40) idle();
    chk("no_partial_publish", vld_n, 0);
    check_outputs();
    step(1'b1, 1'b1, 30, 40, 1'b0);
    frame_end(1'b1, 1'b1, 50, 60);

    // centroid at column 0 / row 0 and edge crosshair behaviour
    step(1'b1, 1'b1, 0, 0, 1'b0);
    frame_end(1'b1, 1'b1, 0, 1);
    step(1'b1, 1'b0, 0, 500, 1'b0);
    step(1'b1, 1'b0, 1, 500, 1'b0);
    step(1'b1, 1'b0, 2, 500, 1'b0);
    step(1'b1, 1'b0, 1279, 500, 1'b0);
    step(1'b1, 1'b0, 900, 719, 1'b0);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int n, pct;
      n   = 10 + int'($urandom % 30);
      pct = (f % 4 == 3) ? 3 : int'($urandom_range(20, 90));
      for (int p = 0; p < n; p++) rand_pixel(pct);
      frame_end($urandom % 2 == 0, $urandom % 2 == 0,
                int'($urandom % 1280), int'($urandom % 720));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
